fir_3x3_conv: RTL
=================

Name: fir_3x3_conv

Overview:
- 3x3 FIR/convolution stage directly downstream of the 3-line window generator.
- Consumes one 3-pixel column per valid cycle (three line taps) plus that column's border code.
- Builds a 3-column window, zero-pads missing neighbours per border code, and computes a weighted sum, shift and saturate.
- Emits one filtered pixel per input column, plus a self-flushed final pixel at frame end.

Parameters:
- WIDTH, 8, pixel width of input and output.
- K00..K22, 1 2 1 / 2 4 2 / 1 2 1, unsigned 4-bit coefficients; Kr c is row r (0 = top), column c (0 = left).
- SHIFT, 4, right-shift applied to the sum before saturation.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- valid_in  in  1  input column valid; driven by the window stage out_en.
- din_r0  in  WIDTH  bottom (newest) line tap.
- din_r1  in  WIDTH  middle line tap.
- din_r2  in  WIDTH  top (oldest) line tap.
- corner_type  in  4  border code of the incoming column:
  - 1 top-left, 2 top-right, 3 left, 4 right
  - 5 bottom-left, 6 bottom-right, 7 bottom, 8 interior
  - 0 and 9-15 are treated as 8.
- dout  out  WIDTH  filtered pixel.
- dout_valid  out  1  dout qualifier, one-cycle pulse per pixel.
- dout_type  out  4  border code of the centre pixel that produced dout.
- frame_done  out  1  one-cycle pulse coincident with the bottom-right pixel output.

Behaviour:
- Reset: one clock, clk; reset asynchronous, active-low on rst_n. On reset, dout, dout_valid, dout_type, frame_done, all window registers and the top_row flag are 0; FSM is IDLE.
- Window: three column slots, L, C, R. On each valid_in, L<=C, C<=R, R<=input column, and the input's corner_type is held with the slot.
  - Output is produced for C, the centre, once its right neighbour has arrived.
  - Latency: dout is registered one cycle after the valid_in that completes the window.
- FSM:
  - IDLE: valid_in loads R. Go to FILL.
  - FILL: one column held and no output yet. Next valid_in shifts. Go to RUN, producing the first output, with centre = first column.
  - RUN: every valid_in shifts and produces one output for the new centre.
    - If the shifted-in column has type 6, go to FLUSH.
  - FLUSH: in the next cycle, with no input needed, shift in a zero column and output the last centre. Pulse frame_done. Go to IDLE.
  - valid_in during FLUSH is ignored.
- Masks, from the centre's type:
  - Left column (L) forced to 0 for types 1, 3, 5.
  - Right column (R) forced to 0 for types 2, 4, 6. This covers the new row's first column sitting in R when the centre is a right-border pixel.
  - Top row (r2) forced to 0 while top_row = 1.
    - top_row is set when a type-1 column enters.
    - top_row is cleared after the type-2 centre has been output.
  - Bottom row (r0) forced to 0 for types 5, 6, 7.
- Arithmetic:
  - Products are unsigned WIDTH x 4.
  - Sum width is WIDTH + 8 bits; no overflow is possible.
  - Result = sum >> SHIFT. If result > 2^WIDTH - 1, dout = 2^WIDTH - 1; otherwise dout = result.
- Handshake: there is no backpressure. Gaps in valid_in stall the window with contents held, and no output is produced during gaps.
- Frame restart:
  - A type-1 column arriving while in RUN, due to a lost frame end, forces an internal flush.
  - That column is then restarted as the first column of the new frame.
- Reset mid-frame clears the window and the FSM immediately, and no partial output is issued.

Test Plan:
- Flat 4x3 image, all pixels 16, default coefficients:
  - Interior -> 16.
  - Top-left -> 9, left edge -> 12, top edge -> 12, bottom-right -> 9.
  - dout_valid count = 12; frame_done pulses once with the type-6 pixel.
- All pixels 255, SHIFT = 0 -> every dout = 255 (saturation); unsaturated interior sum = 4080, checked internally.
- Single 10 impulse at an interior centre, other pixels 0 -> dout pattern 0,1,2,1 / 2,4,2 ... scaled: 10*K >> 4 = 0,1,2 ... matches 10*Kr c >> 4 at each neighbour.
- valid_in gaps of 3 cycles between columns -> output values identical to the gapless run; no dout_valid during gaps.
- Assert rst_n low for one cycle mid-row -> all outputs 0 the same cycle; the next frame produces correct values from its first column.
- A type-1 column injected during RUN -> the pending centre is flushed with R zeroed, then the new frame begins in FILL.

Source files
------------

// File: rtl/fir_3x3_conv.sv
// 3x3 convolution stage: slides a three-column window over the line-tap stream,
// zero-pads borders from the centre's border code, then sums, shifts and saturates.
module fir_3x3_conv #(
  parameter int unsigned WIDTH = 8,
  parameter logic [3:0]  K00   = 4'd1,
  parameter logic [3:0]  K01   = 4'd2,
  parameter logic [3:0]  K02   = 4'd1,
  parameter logic [3:0]  K10   = 4'd2,
  parameter logic [3:0]  K11   = 4'd4,
  parameter logic [3:0]  K12   = 4'd2,
  parameter logic [3:0]  K20   = 4'd1,
  parameter logic [3:0]  K21   = 4'd2,
  parameter logic [3:0]  K22   = 4'd1,
  parameter int unsigned SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] din_r0,
  input  logic [WIDTH-1:0] din_r1,
  input  logic [WIDTH-1:0] din_r2,
  input  logic [3:0]       corner_type,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [3:0]       dout_type,
  output logic             frame_done
);
  localparam int unsigned SUM_W = WIDTH + 8;
  localparam logic [SUM_W-1:0] PIX_MAX = {{8{1'b0}}, {WIDTH{1'b1}}};
  localparam logic [3:0] KERN [3][3] = '{'{K00, K01, K02}, '{K10, K11, K12}, '{K20, K21, K22}};

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_e;

  typedef struct packed {
    logic [3:0]       ctype;
    logic [WIDTH-1:0] r2;
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] r0;
  } col_t;

  localparam col_t ZERO_COL = '0;

  state_e           state_q, state_d;
  col_t             l_q, l_d, c_q, c_d, r_q, r_d;
  logic             top_row_q, top_row_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic [3:0]       dout_type_q, dout_type_d;
  logic             frame_done_q, frame_done_d;

  logic [3:0]       in_type;
  col_t             in_col;
  col_t             win [3];
  logic             emit, done, restart, accept;
  logic             mask_l, mask_r, mask_top, mask_bot, keep;
  logic [WIDTH-1:0] pix;
  logic [SUM_W-1:0] sum, shifted;
  logic [WIDTH-1:0] result;

  // valid_in qualifies one column per cycle; there is no ready, so every valid
  // column is consumed, except during FLUSH where it is dropped.
  always_comb begin
    in_type = (corner_type >= 4'd1 && corner_type <= 4'd8) ? corner_type : 4'd8;
    in_col  = {in_type, din_r2, din_r1, din_r0};
    accept  = valid_in && (state_q != FLUSH);
    state_d = state_q;
    l_d = l_q;
    c_d = c_q;
    r_d = r_q;
    emit    = 1'b0;
    done    = 1'b0;
    restart = 1'b0;
    case (state_q)
      IDLE: if (valid_in) begin
        l_d = ZERO_COL; c_d = ZERO_COL; r_d = in_col;
        state_d = FILL;
      end
      FILL: if (valid_in) begin
        l_d = c_q; c_d = r_q; r_d = in_col;
        emit = 1'b1;
        state_d = RUN;
      end
      RUN: if (valid_in) begin
        emit = 1'b1;
        if (in_type == 4'd1) begin
          // Lost frame end: flush the pending centre and reuse this column as a new frame start.
          restart = 1'b1;
          l_d = ZERO_COL; c_d = ZERO_COL; r_d = in_col;
          state_d = FILL;
        end else begin
          l_d = c_q; c_d = r_q; r_d = in_col;
          if (in_type == 4'd6) state_d = FLUSH;
        end
      end
      FLUSH: begin
        l_d = c_q; c_d = r_q; r_d = ZERO_COL;
        emit = 1'b1;
        done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (restart) win = '{c_q, r_q, ZERO_COL};
    else         win = '{l_d, c_d, r_d};

    top_row_d = top_row_q;
    if (emit && win[1].ctype == 4'd2) top_row_d = 1'b0;
    if (accept && in_type == 4'd1)    top_row_d = 1'b1;

    dout_valid_d = emit;
    frame_done_d = done;
    dout_d       = emit ? result : dout_q;
    dout_type_d  = emit ? win[1].ctype : dout_type_q;
  end

  always_comb begin
    mask_l   = win[1].ctype inside {4'd1, 4'd3, 4'd5};
    mask_r   = win[1].ctype inside {4'd2, 4'd4, 4'd6};
    mask_top = top_row_q;
    mask_bot = win[1].ctype inside {4'd5, 4'd6, 4'd7};
    pix  = '0;
    keep = 1'b0;
    sum  = '0;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 3; r++) begin
        pix  = (r == 0) ? win[c].r2 : ((r == 1) ? win[c].r1 : win[c].r0);
        keep = !((c == 0 && mask_l) || (c == 2 && mask_r) ||
                 (r == 0 && mask_top) || (r == 2 && mask_bot));
        if (keep) sum = sum + SUM_W'(pix) * SUM_W'(KERN[r][c]);
      end
    end
    shifted = sum >> SHIFT;
    result  = (shifted > PIX_MAX) ? {WIDTH{1'b1}} : shifted[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      l_q          <= '0;
      c_q          <= '0;
      r_q          <= '0;
      top_row_q    <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_type_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      l_q          <= l_d;
      c_q          <= c_d;
      r_q          <= r_d;
      top_row_q    <= top_row_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_type_q  <= dout_type_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_type  = dout_type_q;
  assign frame_done = frame_done_q;

endmodule
